// File: rtl/butterfly_weight_scheduler.sv
// Weight-load and start sequencer for one butterfly FFT job.
// It streams repacked SRAM weights, pulses start, then counts output beats.
module butterfly_weight_scheduler #(
  parameter int data_width     = 16,
  parameter int bu_parallelism = 4,
  parameter int MAX_LENGTH     = 1024,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT        = 65535
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  cfg_start,
  input  logic [15:0]                           cfg_length,
  input  logic [ADDR_WIDTH-1:0]                 cfg_base_addr,
  input  logic                                  abort,
  output logic                                  wmem_rd_en,
  output logic [ADDR_WIDTH-1:0]                 wmem_addr,
  input  logic [2*data_width*bu_parallelism-1:0] wmem_rd_dat,
  output logic [4*data_width*bu_parallelism-1:0] up_weight_dat,
  output logic                                  up_weight_vld,
  output logic                                  bfly_start,
  input  logic                                  out_beat,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err,
  output logic [3:0]                            stage_idx
);

  localparam int LOGMAX = $clog2(MAX_LENGTH);
  localparam int WCW    = $clog2(MAX_LENGTH * LOGMAX + 1);
  localparam int OUTW   = 4 * data_width * bu_parallelism;
  localparam int TOW    = $clog2(TIMEOUT + 1);
  localparam int MINLEN = 2 * bu_parallelism;
  localparam int BUSH   = $clog2(MINLEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_START,
    S_RUN,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           len_q;
  logic [WCW-1:0]        depth_q;
  logic [WCW-1:0]        total_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [WCW-1:0]        lin_q;
  logic [WCW-1:0]        wsub_q;
  logic [3:0]            stage_q;
  logic                  drain_q;
  logic [15:0]           beat_q;
  logic [TOW-1:0]        wd_q;
  logic                  err_q, err_d;
  logic                  rd_vld_q;
  logic                  vld_q;
  logic [OUTW-1:0]       dat_q;
  logic [OUTW-1:0]       pack_d;

  logic                  accept;
  logic                  len_pow2;
  logic                  len_ok;
  logic [3:0]            len_log2;
  logic [WCW-1:0]        depth_new;
  logic [WCW-1:0]        stages_new;
  logic [WCW-1:0]        total_new;
  logic                  lin_last;
  logic                  beat_last;
  logic                  wd_hit;

  // Highest set bit gives log2 once the length is known to be a power of two.
  always_comb begin
    len_log2 = '0;
    for (int i = 0; i < 16; i++) begin
      if (cfg_length[i]) len_log2 = 4'(i);
    end
  end

  assign len_pow2 = (cfg_length != '0) &&
                    ((cfg_length & (cfg_length - 16'd1)) == '0);
  assign len_ok   = len_pow2 &&
                    (cfg_length >= 16'(MINLEN)) &&
                    (cfg_length <= 16'(MAX_LENGTH));

  assign depth_new  = WCW'(cfg_length >> BUSH);
  assign stages_new = WCW'(len_log2);
  assign total_new  = stages_new * depth_new;

  assign lin_last  = (lin_q == total_q - WCW'(1));
  assign beat_last = out_beat && (beat_q == len_q - 16'd1);
  assign wd_hit    = (wd_q == TOW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    accept  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cfg_start) begin
            if (len_ok) begin
              state_d = S_LOAD;
              accept  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (lin_last) state_d = S_DRAIN;
        end
        S_DRAIN: begin
          if (drain_q) state_d = S_START;
        end
        S_START: state_d = S_RUN;
        S_RUN: begin
          if (beat_last) begin
            state_d = S_DONE;
          end else if (wd_hit) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      drain_q <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      drain_q <= (state_q == S_DRAIN);
      wd_q    <= (state_q == S_RUN) ? wd_q + TOW'(1) : '0;
    end
  end

  // Job parameters and the stage-major word walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q   <= '0;
      depth_q <= '0;
      total_q <= '0;
      base_q  <= '0;
      lin_q   <= '0;
      wsub_q  <= '0;
      stage_q <= '0;
      beat_q  <= '0;
    end else if (accept) begin
      len_q   <= cfg_length;
      depth_q <= depth_new;
      total_q <= total_new;
      base_q  <= cfg_base_addr;
      lin_q   <= '0;
      wsub_q  <= '0;
      stage_q <= '0;
      beat_q  <= '0;
    end else begin
      if (state_q == S_LOAD && !abort && !lin_last) begin
        lin_q <= lin_q + WCW'(1);
        if (wsub_q == depth_q - WCW'(1)) begin
          wsub_q  <= '0;
          stage_q <= stage_q + 4'd1;
        end else begin
          wsub_q <= wsub_q + WCW'(1);
        end
      end
      if (state_q == S_RUN && out_beat && beat_q != len_q) begin
        beat_q <= beat_q + 16'd1;
      end
    end
  end

  always_comb begin
    pack_d = '0;
    for (int k = 0; k < bu_parallelism; k++) begin
      pack_d[data_width*(4*k) +: data_width] =
        wmem_rd_dat[2*data_width*k +: data_width];
      pack_d[data_width*(4*k+1) +: data_width] =
        wmem_rd_dat[2*data_width*k+data_width +: data_width];
    end
  end

  // Abort kills both in-flight weight slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q <= 1'b0;
      vld_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      rd_vld_q <= (state_q == S_LOAD) && !abort;
      vld_q    <= rd_vld_q && !abort;
      if (rd_vld_q) dat_q <= pack_d;
    end
  end

  assign wmem_rd_en    = (state_q == S_LOAD);
  assign wmem_addr     = (state_q == S_LOAD) ?
                         base_q + ADDR_WIDTH'(lin_q) : '0;
  assign up_weight_dat = dat_q;
  assign up_weight_vld = vld_q;
  assign bfly_start    = (state_q == S_START);
  assign busy          = (state_q == S_LOAD) || (state_q == S_DRAIN) ||
                         (state_q == S_START) || (state_q == S_RUN);
  assign done          = (state_q == S_DONE);
  assign err           = err_q;
  assign stage_idx     = stage_q;

endmodule

// File: tb/tb_butterfly_weight_scheduler.sv
// Scoreboard bench for butterfly_weight_scheduler.
// A second instance with a short watchdog covers the timeout path.
module tb_butterfly_weight_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_start;
  logic [15:0]  cfg_length;
  logic [15:0]  cfg_base_addr;
  logic         abort;
  logic         wmem_rd_en;
  logic [15:0]  wmem_addr;
  logic [127:0] wmem_rd_dat;
  logic [255:0] up_weight_dat;
  logic         up_weight_vld;
  logic         bfly_start;
  logic         out_beat;
  logic         busy;
  logic         done;
  logic         err;
  logic [3:0]   stage_idx;

  logic         w_start;
  logic         w_abort;
  logic         w_beat;
  logic [127:0] w_rd_dat;
  logic         w_rd_en;
  logic [15:0]  w_addr;
  logic [255:0] w_dat;
  logic         w_vld;
  logic         w_bstart;
  logic         w_busy;
  logic         w_done;
  logic         w_err;
  logic [3:0]   w_stage;

  int tests = 0;
  int fails = 0;
  logic [255:0] sbq[$];

  always #5 clk = ~clk;

  butterfly_weight_scheduler u_dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_length(cfg_length),
    .cfg_base_addr(cfg_base_addr), .abort(abort),
    .wmem_rd_en(wmem_rd_en), .wmem_addr(wmem_addr),
    .wmem_rd_dat(wmem_rd_dat), .up_weight_dat(up_weight_dat),
    .up_weight_vld(up_weight_vld), .bfly_start(bfly_start),
    .out_beat(out_beat), .busy(busy), .done(done), .err(err),
    .stage_idx(stage_idx)
  );

  butterfly_weight_scheduler #(.TIMEOUT(100)) u_wd (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(w_start), .cfg_length(cfg_length),
    .cfg_base_addr(cfg_base_addr), .abort(w_abort),
    .wmem_rd_en(w_rd_en), .wmem_addr(w_addr),
    .wmem_rd_dat(w_rd_dat), .up_weight_dat(w_dat),
    .up_weight_vld(w_vld), .bfly_start(w_bstart),
    .out_beat(w_beat), .busy(w_busy), .done(w_done), .err(w_err),
    .stage_idx(w_stage)
  );

  function automatic logic [127:0] mem_fn(input logic [15:0] a);
    logic [127:0] r;
    logic [15:0] re, im;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      if (a == 16'h0200) begin
        re = 16'h3C00 + 16'(k) * 16'h0100;
        im = 16'hBC00 + 16'(k) * 16'h0100;
      end else begin
        re = a * 16'd3 + 16'(k) * 16'h1111;
        im = ~a ^ (16'(k) * 16'h0707);
      end
      r[32*k +: 16]    = re;
      r[32*k+16 +: 16] = im;
    end
    return r;
  endfunction

  function automatic logic [255:0] exp_pack(input logic [15:0] a);
    logic [127:0] m;
    logic [255:0] r;
    m = mem_fn(a);
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[64*k +: 16]    = m[32*k +: 16];
      r[64*k+16 +: 16] = m[32*k+16 +: 16];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (wmem_rd_en) wmem_rd_dat <= mem_fn(wmem_addr);
  end

  always @(negedge clk) begin
    if (rst_n && up_weight_vld) begin
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL sb_extra_vld: got vld=1, required no weight at %0t",
                 $time);
      end else begin
        logic [255:0] e;
        e = sbq.pop_front();
        if (up_weight_dat !== e) begin
          fails++;
          $display("FAIL sb_weight: got %h required %h", up_weight_dat, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int len, input logic [15:0] base,
                         input bit hold, input bit early);
    int depth, stages, total, rr;
    depth  = len / 8;
    stages = $clog2(len);
    total  = stages * depth;
    rr     = total + 4;
    cfg_length    = 16'(len);
    cfg_base_addr = base;
    cfg_start     = 1'b1;
    for (int c = 1; c <= rr + len; c++) begin
      tick();
      if (!hold || c == rr + len) cfg_start = 1'b0;
      out_beat = (c >= rr && c < rr + len) ||
                 (early && c >= total + 1 && c <= total + 3);
      tests++;
      if (wmem_rd_en !== (c <= total)) begin
        fails++;
        $display("FAIL job_rd_en c=%0d: got %b required %b",
                 c, wmem_rd_en, c <= total);
      end
      if (c <= total) begin
        tests++;
        if (wmem_addr !== 16'(base + 16'(c - 1)) ||
            stage_idx !== 4'((c - 1) / depth)) begin
          fails++;
          $display("FAIL job_addr c=%0d: got %h/%0d required %h/%0d",
                   c, wmem_addr, stage_idx, 16'(base + 16'(c - 1)),
                   (c - 1) / depth);
        end
        sbq.push_back(exp_pack(16'(base + 16'(c - 1))));
      end
      tests++;
      if (up_weight_vld !== (c >= 3 && c <= total + 2) ||
          bfly_start !== (c == total + 3)) begin
        fails++;
        $display("FAIL job_vld_start c=%0d: got %b/%b", c,
                 up_weight_vld, bfly_start);
      end
      tests++;
      if (done !== (c == rr + len) || busy !== (c < rr + len) ||
          err !== 1'b0) begin
        fails++;
        $display("FAIL job_status c=%0d: got done=%b busy=%b err=%b",
                 c, done, busy, err);
      end
    end
    tests++;
    if (stage_idx !== 4'(stages - 1)) begin
      fails++;
      $display("FAIL job_stage_hold: got %0d required %0d",
               stage_idx, stages - 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_start = 0; cfg_length = 0; cfg_base_addr = 0;
    abort = 0; out_beat = 0;
    w_start = 0; w_abort = 0; w_beat = 0; w_rd_dat = '0;
    wmem_rd_dat = '0;
    #12;
    tests++;
    if ({wmem_rd_en, up_weight_vld, bfly_start, busy, done, err} !== 6'b0 ||
        wmem_addr !== 16'h0 || up_weight_dat !== '0 || stage_idx !== 4'h0) begin
      fails++;
      $display("FAIL reset_outputs: got rd=%b vld=%b st=%b busy=%b done=%b err=%b",
               wmem_rd_en, up_weight_vld, bfly_start, busy, done, err);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if (busy !== 1'b0 || wmem_rd_en !== 1'b0 || w_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b rd=%b", busy, wmem_rd_en);
    end
  endtask

  task automatic test_nominal();
    run_job(256, 16'h0100, 1'b0, 1'b1);
    tick();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || sbq.size() != 0) begin
      fails++;
      $display("FAIL nominal_after: got done=%b busy=%b sbq=%0d required 0/0/0",
               done, busy, sbq.size());
    end
  endtask

  task automatic test_repack();
    cfg_length = 16'd8; cfg_base_addr = 16'h0200; cfg_start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      cfg_start = 1'b0;
      if (c == 1) sbq.push_back(exp_pack(16'h0200));
    end
    for (int k = 0; k < 4; k++) begin
      logic [15:0] re, im;
      re = 16'h3C00 + 16'(k) * 16'h0100;
      im = 16'hBC00 + 16'(k) * 16'h0100;
      tests++;
      if (up_weight_vld !== 1'b1 ||
          up_weight_dat[64*k +: 16] !== re ||
          up_weight_dat[64*k+16 +: 16] !== im ||
          up_weight_dat[64*k+32 +: 32] !== 32'h0) begin
        fails++;
        $display("FAIL repack_lane%0d: got %h required %h %h 0 0",
                 k, up_weight_dat[64*k +: 64], re, im);
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tests++;
      if (up_weight_vld !== 1'b0 || busy !== 1'b0 || wmem_rd_en !== 1'b0) begin
        fails++;
        $display("FAIL repack_abort c=%0d: got vld=%b busy=%b rd=%b",
                 c, up_weight_vld, busy, wmem_rd_en);
      end
      tick();
    end
  endtask

  task automatic test_bad_config();
    logic [15:0] lens[3];
    lens[0] = 16'd200; lens[1] = 16'd4; lens[2] = 16'd2048;
    for (int i = 0; i < 3; i++) begin
      cfg_length = lens[i]; cfg_base_addr = 16'h0700; cfg_start = 1'b1;
      for (int c = 1; c <= 4; c++) begin
        tick();
        cfg_start = 1'b0;
        tests++;
        if (err !== (c == 1) || wmem_rd_en !== 1'b0 || busy !== 1'b0) begin
          fails++;
          $display("FAIL bad_cfg len=%0d c=%0d: got err=%b rd=%b busy=%b",
                   lens[i], c, err, wmem_rd_en, busy);
        end
      end
    end
  endtask

  task automatic test_abort();
    cfg_length = 16'd256; cfg_base_addr = 16'h0100; cfg_start = 1'b1;
    for (int c = 1; c <= 41; c++) begin
      tick();
      cfg_start = 1'b0;
      if (c <= 39) sbq.push_back(exp_pack(16'(16'h0100 + 16'(c - 1))));
    end
    tests++;
    if (wmem_addr !== 16'h0128 || stage_idx !== 4'd1) begin
      fails++;
      $display("FAIL abort_word40: got %h/%0d required 0128/1",
               wmem_addr, stage_idx);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tests++;
      if (wmem_rd_en !== 1'b0 || up_weight_vld !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || err !== 1'b0 || stage_idx !== 4'd1) begin
        fails++;
        $display("FAIL abort_quiet c=%0d: got rd=%b vld=%b busy=%b done=%b err=%b stg=%0d",
                 c, wmem_rd_en, up_weight_vld, busy, done, err, stage_idx);
      end
      tick();
    end
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL abort_sb: got %0d pending required 0", sbq.size());
    end
    run_job(8, 16'h0040, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_abort_start();
    cfg_length = 16'd8; cfg_base_addr = 16'h0050;
    cfg_start = 1'b1; abort = 1'b1;
    tick();
    cfg_start = 1'b0; abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tests++;
      if (busy !== 1'b0 || wmem_rd_en !== 1'b0 || err !== 1'b0) begin
        fails++;
        $display("FAIL abort_start c=%0d: got busy=%b rd=%b err=%b",
                 c, busy, wmem_rd_en, err);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    run_job(8, 16'h0300, 1'b0, 1'b0);
    tick();
    run_job(16, 16'h0310, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_robust();
    run_job(8, 16'h0400, 1'b1, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      tick();
      out_beat = (c <= 5);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0 || wmem_rd_en !== 1'b0) begin
        fails++;
        $display("FAIL robust_after c=%0d: got done=%b busy=%b rd=%b",
                 c, done, busy, wmem_rd_en);
      end
    end
    out_beat = 1'b0;
  endtask

  task automatic test_timeout();
    cfg_length = 16'd16; cfg_base_addr = 16'h0500; w_start = 1'b1;
    for (int c = 1; c <= 113; c++) begin
      tick();
      w_start = 1'b0;
      w_beat = (c >= 12 && c < 22);
      if (c == 1 || c == 3 || c == 8 || c == 11) begin
        tests++;
        if ((c == 1 && (w_rd_en !== 1'b1 || w_addr !== 16'h0500)) ||
            (c == 3 && (w_vld !== 1'b1 || w_dat !== '0)) ||
            (c == 8 && w_stage !== 4'd3) ||
            (c == 11 && w_bstart !== 1'b1)) begin
          fails++;
          $display("FAIL wd_load c=%0d: got rd=%b addr=%h vld=%b stg=%0d st=%b",
                   c, w_rd_en, w_addr, w_vld, w_stage, w_bstart);
        end
      end
      tests++;
      if (w_err !== (c == 112) || w_busy !== (c < 112) || w_done !== 1'b0) begin
        fails++;
        $display("FAIL wd_timeout c=%0d: got err=%b busy=%b done=%b",
                 c, w_err, w_busy, w_done);
      end
    end
    w_beat = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_repack();
    test_bad_config();
    test_abort();
    test_abort_start();
    test_back_to_back();
    test_robust();
    test_timeout();
    tick();
    tests++;
    if (sbq.size() != 0 || w_vld !== 1'b0) begin
      fails++;
      $display("FAIL final_drain: got %0d pending, w_vld=%b required 0/0",
               sbq.size(), w_vld);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
